div_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU around the one-bit restoring step div_iter.

---
 rtl/rv32im_pkg.sv | 30 +++
 rtl/div_iter.sv | 23 ++
 rtl/div_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared RV32M divider definitions: operation encodings, sequencer states and a
// conditional two's-complement helper.
package rv32im_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } div_state_e;

   typedef enum logic [1:0] {
      SP_NONE = 2'b00,
      SP_DIV0 = 2'b01,
      SP_OVF  = 2'b10,
      SP_BIG  = 2'b11
   } div_special_e;

   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? (32'h0000_0000 - v) : v;
   endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the resulting quotient bit.
module div_iter
   import rv32im_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            dividend_bit_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_bit_o
);

   logic [XLEN:0] shifted_s;
   logic [XLEN:0] diff_s;

   // The remainder stays below a divisor whose bit 31 is clear, so 33 bits
   // are enough for the trial subtraction to be exact.
   assign shifted_s = {rem_i, dividend_bit_i};
   assign diff_s    = shifted_s - {1'b0, divisor_i};
   assign q_bit_o   = ~diff_s[XLEN];
   assign rem_o     = diff_s[XLEN] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer around a chain of div_iter
// stages; sign stripping, special cases and sign fix-up are handled locally.
module div_seq_ctrl
   import rv32im_pkg::*;
#(
   parameter int ITERS_PER_CYCLE = 1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int COUNT_INIT = XLEN / ITERS_PER_CYCLE;
   localparam int LOG2_IPC   = $clog2(ITERS_PER_CYCLE);

   div_state_e      state_q;
   div_special_e    special_q, special_s;
   logic [XLEN-1:0] a_q, b_q, rem_q, quot_q, result_q;
   logic [XLEN-1:0] rem_d, quot_d, result_d;
   logic [5:0]      count_q, count_d, iters_done_s;
   logic            neg_quot_q, neg_rem_q, sel_rem_q, busy_q, done_q;
   logic            is_signed_s, sa_s, sb_s;
   logic [XLEN-1:0] abs_a_s, abs_b_s, q_raw_s, r_raw_s, q_fix_s, r_fix_s;
   logic [ITERS_PER_CYCLE-1:0]   q_bits_s;
   logic [5*ITERS_PER_CYCLE-1:0] idx_all_s;

   assign is_signed_s = (op == OP_DIV) || (op == OP_REM);
   assign sa_s        = is_signed_s & dividend[XLEN-1];
   assign sb_s        = is_signed_s & divisor[XLEN-1];
   assign abs_a_s     = neg_if(sa_s, dividend);
   assign abs_b_s     = neg_if(sb_s, divisor);

   // Classify the incoming operands; anything but SP_NONE skips CALC.
   always_comb begin
      if (divisor == 32'h0000_0000) begin
         special_s = SP_DIV0;
      end else if (is_signed_s && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) begin
         special_s = SP_OVF;
      end else if (abs_b_s[XLEN-1]) begin
         special_s = SP_BIG;
      end else begin
         special_s = SP_NONE;
      end
   end

   assign iters_done_s = (6'(COUNT_INIT) - count_q) << LOG2_IPC;
   assign count_d      = count_q - 6'd1;

   for (genvar g = 0; g < ITERS_PER_CYCLE; g++) begin : g_stage
      logic [XLEN-1:0] rem_in_s;
      logic [XLEN-1:0] rem_out_s;
      assign idx_all_s[5*g +: 5] = 5'(6'd31 - iters_done_s - 6'(g));
      if (g == 0) begin : g_head
         assign rem_in_s = rem_q;
      end else begin : g_link
         assign rem_in_s = g_stage[g-1].rem_out_s;
      end
      div_iter u_div_iter (
         .rem_i          (rem_in_s),
         .divisor_i      (b_q),
         .dividend_bit_i (a_q[idx_all_s[5*g +: 5]]),
         .rem_o          (rem_out_s),
         .q_bit_o        (q_bits_s[g])
      );
   end

   assign rem_d = g_stage[ITERS_PER_CYCLE-1].rem_out_s;

   // Quotient bits land at the same descending positions the dividend bits came from.
   always_comb begin
      quot_d = quot_q;
      for (int j = 0; j < ITERS_PER_CYCLE; j++) begin
         quot_d[idx_all_s[5*j +: 5]] = q_bits_s[j];
      end
   end

   // Final magnitude selection, sign fix-up and quotient/remainder select.
   always_comb begin
      q_raw_s = quot_q;
      r_raw_s = rem_q;
      case (special_q)
         SP_DIV0: begin
            q_raw_s = 32'hFFFF_FFFF;
            r_raw_s = a_q;
         end
         SP_OVF: begin
            q_raw_s = 32'h8000_0000;
            r_raw_s = 32'h0000_0000;
         end
         SP_BIG: begin
            q_raw_s = (a_q >= b_q) ? 32'h0000_0001 : 32'h0000_0000;
            r_raw_s = (a_q >= b_q) ? (a_q - b_q) : a_q;
         end
         default: begin
            q_raw_s = quot_q;
            r_raw_s = rem_q;
         end
      endcase
      q_fix_s  = (special_q == SP_DIV0) ? 32'hFFFF_FFFF : neg_if(neg_quot_q, q_raw_s);
      r_fix_s  = neg_if(neg_rem_q, r_raw_s);
      result_d = sel_rem_q ? r_fix_s : q_fix_s;
   end

   // Sequencer FSM with registered busy/done/result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         special_q  <= SP_NONE;
         a_q        <= 32'h0000_0000;
         b_q        <= 32'h0000_0000;
         rem_q      <= 32'h0000_0000;
         quot_q     <= 32'h0000_0000;
         count_q    <= 6'd0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         sel_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= 32'h0000_0000;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (start && !flush) begin
                  a_q        <= abs_a_s;
                  b_q        <= abs_b_s;
                  neg_quot_q <= sa_s ^ sb_s;
                  neg_rem_q  <= sa_s;
                  sel_rem_q  <= op[1];
                  special_q  <= special_s;
                  rem_q      <= 32'h0000_0000;
                  quot_q     <= 32'h0000_0000;
                  count_q    <= 6'(COUNT_INIT);
                  busy_q     <= 1'b1;
                  state_q    <= (special_s == SP_NONE) ? ST_CALC : ST_FIX;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_q   <= rem_d;
                  quot_q  <= quot_d;
                  count_q <= count_d;
                  state_q <= (count_d == 6'd0) ? ST_FIX : ST_CALC;
               end
            end
            ST_FIX: begin
               busy_q <= 1'b0;
               if (flush) begin
                  state_q <= ST_IDLE;
               end else begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: one instance with 1 and one with 4 iterations per
// cycle, a timeline reference model checked every cycle, plus literal vectors.
module tb_div_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start_s [2] = '{1'b0, 1'b0};
   logic        flush_s [2] = '{1'b0, 1'b0};
   logic [1:0]  op_s    [2] = '{2'b00, 2'b00};
   logic [31:0] a_s     [2] = '{32'h0, 32'h0};
   logic [31:0] b_s     [2] = '{32'h0, 32'h0};
   logic        busy_o  [2];
   logic        done_o  [2];
   logic [31:0] res_o   [2];
   int          ipc     [2] = '{1, 4};

   div_seq_ctrl #(.ITERS_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .dividend(a_s[0]),
      .divisor(b_s[0]), .flush(flush_s[0]), .busy(busy_o[0]), .done(done_o[0]), .result(res_o[0]));
   div_seq_ctrl #(.ITERS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .dividend(a_s[1]),
      .divisor(b_s[1]), .flush(flush_s[1]), .busy(busy_o[1]), .done(done_o[1]), .result(res_o[1]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h, required %h", name, d, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int si, sj;
      logic [31:0] q, r;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'h0;
      end else if (!op[0]) begin
         si = a; sj = b;
         q = si / sj; r = si % sj;
      end else begin
         q = a / b; r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
      bit sp;
      sp = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (op[0] ? b[31] : (b == 32'h8000_0000));
      return sp ? 2 : (32 / n) + 2;
   endfunction

   // Reference model: elapsed cycles since an accepted start, per instance.
   bit          m_pend [2];
   int          m_k    [2];
   int          m_lat  [2];
   logic [31:0] m_val  [2];
   logic [31:0] m_res  [2];

   initial begin
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rst) begin
               m_pend[d] = 1'b0;
               m_res[d]  = 32'h0;
            end else if (m_pend[d] && m_k[d] < m_lat[d]) begin
               if (flush_s[d]) m_pend[d] = 1'b0;
               else begin
                  m_k[d]++;
                  if (m_k[d] == m_lat[d]) m_res[d] = m_val[d];
               end
            end else begin
               m_pend[d] = 1'b0;
               if (start_s[d] && !flush_s[d]) begin
                  m_pend[d] = 1'b1;
                  m_k[d]    = 1;
                  m_lat[d]  = ref_lat(op_s[d], a_s[d], b_s[d], ipc[d]);
                  m_val[d]  = ref_result(op_s[d], a_s[d], b_s[d]);
               end
            end
         end
         #1;
         for (int d = 0; d < 2; d++) begin
            check("model_busy", d, {31'd0, busy_o[d]}, {31'd0, m_pend[d] && (m_k[d] < m_lat[d])});
            check("model_done", d, {31'd0, done_o[d]}, {31'd0, m_pend[d] && (m_k[d] == m_lat[d])});
            check("model_result", d, res_o[d], m_res[d]);
         end
      end
   end

   task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      start_s[d] = 1'b1; op_s[d] = op; a_s[d] = a; b_s[d] = b;
   endtask

   // Waits for done; optionally pokes start (ignored) or flush at cycle 'poke'.
   task automatic wait_done(input int d, input string name, input int exp_lat, input logic [31:0] exp,
                            input int poke, input bit poke_flush);
      int found = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) start_s[d] = 1'b0;
         if (done_o[d]) begin
            found = k;
            break;
         end
         if (poke != 0 && k == poke) begin
            if (poke_flush) flush_s[d] = 1'b1;
            else issue(d, 2'b01, 32'd1000, 32'd3);
         end
         if (poke != 0 && k == poke + 1) begin
            flush_s[d] = 1'b0;
            start_s[d] = 1'b0;
            if (poke_flush) check("flush_busy", d, {31'd0, busy_o[d]}, 32'd0);
         end
      end
      check({"lat_", name}, d, found, exp_lat);
      if (exp_lat != 0) check({"res_", name}, d, res_o[d], exp);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          spec;
   } vec_t;
   vec_t vecs [18];

   initial begin
      vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
      vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
      vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
      vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
      vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
      vecs[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1'b1};
      vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
      vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
      vecs[9]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          1'b1};
      vecs[10] = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  1'b1};
      vecs[11] = '{2'b00, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[12] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1};
      vecs[13] = '{2'b01, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  1'b0};
      vecs[14] = '{2'b00, 32'h8000_0000,  32'h8000_0000,  32'd1,          1'b1};
      vecs[15] = '{2'b10, 32'd5,          32'h8000_0000,  32'd5,          1'b1};
      vecs[16] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};
      vecs[17] = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0};

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_busy", d, {31'd0, busy_o[d]}, 32'd0);
         check("rst_done", d, {31'd0, done_o[d]}, 32'd0);
         check("rst_result", d, res_o[d], 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 18; i++)
         check($sformatf("model_pin%0d", i), 0, ref_result(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);

      for (int d = 0; d < 2; d++) begin
         int nlat;
         nlat = (d == 0) ? 34 : 10;
         for (int i = 0; i < 18; i++) begin
            issue(d, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(d, $sformatf("vec%0d", i), vecs[i].spec ? 2 : nlat, vecs[i].exp, 0, 1'b0);
            @(negedge clk);
         end

         issue(d, 2'b01, 32'd100, 32'd7);
         wait_done(d, "start_while_busy", nlat, 32'd14, (d == 0) ? 10 : 5, 1'b0);
         repeat (3) @(negedge clk);

         issue(d, 2'b01, 32'd1000, 32'd3);
         wait_done(d, "flush", 0, 32'd0, (d == 0) ? 20 : 6, 1'b1);
         check("flush_result_kept", d, res_o[d], 32'd14);

         issue(d, 2'b00, 32'hFFFF_FFF9, 32'd2);
         wait_done(d, "b2b_first", nlat, 32'hFFFF_FFFD, 0, 1'b0);
         issue(d, 2'b10, 32'd7, 32'hFFFF_FFFE);
         wait_done(d, "b2b_second", nlat, 32'd1, 0, 1'b0);
         repeat (3) @(negedge clk);
      end

      issue(0, 2'b01, 32'd100, 32'd7);
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 0, {31'd0, busy_o[0]}, 32'd0);
      check("midrst_result", 0, res_o[0], 32'd0);
      wait_done(0, "midrst_no_done", 0, 32'd0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
